// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared definitions for the unified program/data RAM port arbiter:
// FSM state encoding, grant encoding, datapath widths and the
// address range check used by both request ports.
package mem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int INST_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_HI  = 2'd1,
        I_CAP = 2'd2,
        D_CAP = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    // True when a byte address lies at or above 4<<aw, i.e. outside the RAM.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
        return ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-requester round-robin arbiter. When both ports request, the one
// that was not granted last wins. The last-grant memory resets to the
// fetch port, so the first conflict after reset goes to the data port.
// Ports:
//   clk_i, rstn_i   clock, asynchronous active-low reset
//   req_fetch_i     fetch port request (already qualified by the caller)
//   req_data_i      data port request (already qualified by the caller)
//   update_i        a grant is being taken this cycle; remember its winner
//   gnt_valid_o     some request is granted
//   gnt_sel_o       which port is granted (meaningful with gnt_valid_o)
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   clk_i,
    input  logic   rstn_i,
    input  logic   req_fetch_i,
    input  logic   req_data_i,
    input  logic   update_i,
    output logic   gnt_valid_o,
    output grant_e gnt_sel_o
);

    grant_e r_last_grant;

    always_comb begin
        gnt_valid_o = req_fetch_i | req_data_i;
        gnt_sel_o   = GNT_I;
        if (req_fetch_i && req_data_i) begin
            gnt_sel_o = (r_last_grant == GNT_I) ? GNT_D : GNT_I;
        end else if (req_data_i) begin
            gnt_sel_o = GNT_D;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_last_grant <= GNT_I;
        end else if (update_i) begin
            r_last_grant <= gnt_sel_o;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, 32-bit, synchronous-read RAM between the core's
// instruction-fetch port and data port. Requests are arbitrated
// round-robin; a 64-bit fetch is sequenced as two RAM beats.
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   mem_i_*              fetch request (rd, pc), accept, response (valid, error, inst)
//   mem_d_*              data request (addr, data_wr, rd, wr, req_tag), accept,
//                        response (ack, error, data_rd, resp_tag)
//   ram_*                RAM strobe, byte enables, word address, write/read data
// Latency from accept in cycle T: write ack T+1, read ack T+2,
// fetch valid T+3, any error response T+1.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RAM_AW = 15,
    parameter int TAG_W  = 11
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              mem_i_rd_i,
    input  logic [31:0]       mem_i_pc_i,
    output logic              mem_i_accept_o,
    output logic              mem_i_valid_o,
    output logic              mem_i_error_o,
    output logic [INST_W-1:0] mem_i_inst_o,
    input  logic [31:0]       mem_d_addr_i,
    input  logic [DATA_W-1:0] mem_d_data_wr_i,
    input  logic              mem_d_rd_i,
    input  logic [3:0]        mem_d_wr_i,
    input  logic [TAG_W-1:0]  mem_d_req_tag_i,
    output logic              mem_d_accept_o,
    output logic              mem_d_ack_o,
    output logic              mem_d_error_o,
    output logic [DATA_W-1:0] mem_d_data_rd_o,
    output logic [TAG_W-1:0]  mem_d_resp_tag_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    arb_state_e r_state;
    arb_state_e w_state_next;

    logic [RAM_AW-1:0] r_fetch_addr;
    logic [DATA_W-1:0] r_inst_lo;
    logic [TAG_W-1:0]  r_d_tag_pend;

    logic              r_i_valid;
    logic              r_i_error;
    logic [INST_W-1:0] r_inst;
    logic              r_d_ack;
    logic              r_d_error;
    logic [DATA_W-1:0] r_d_rdata;
    logic [TAG_W-1:0]  r_d_tag;

    logic   w_idle;
    logic   w_req_i;
    logic   w_req_d;
    logic   w_d_is_wr;
    logic   w_i_err;
    logic   w_d_err;
    logic   w_gnt_valid;
    grant_e w_gnt_sel;
    logic   w_acc_i;
    logic   w_acc_d;

    // Requests are only eligible in IDLE. Gating with rstn_i keeps the
    // accept and RAM strobes low while reset is held, even if requests are.
    assign w_idle    = (r_state == IDLE) && rstn_i;
    assign w_d_is_wr = |mem_d_wr_i;
    assign w_req_i   = w_idle && mem_i_rd_i;
    assign w_req_d   = w_idle && (mem_d_rd_i || w_d_is_wr);

    // Fetches must be 8-byte aligned so the high word never crosses the top.
    assign w_i_err = (|mem_i_pc_i[2:0]) || addr_out_of_range(mem_i_pc_i, RAM_AW);
    assign w_d_err = addr_out_of_range(mem_d_addr_i, RAM_AW);

    rr_arb2 u_rr_arb2 (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .req_fetch_i (w_req_i),
        .req_data_i  (w_req_d),
        .update_i    (w_gnt_valid),
        .gnt_valid_o (w_gnt_valid),
        .gnt_sel_o   (w_gnt_sel)
    );

    assign w_acc_i = w_gnt_valid && (w_gnt_sel == GNT_I);
    assign w_acc_d = w_gnt_valid && (w_gnt_sel == GNT_D);

    assign mem_i_accept_o = w_acc_i;
    assign mem_d_accept_o = w_acc_d;

    always_comb begin
        w_state_next = r_state;
        ram_en_o     = 1'b0;
        ram_we_o     = 4'b0000;
        ram_addr_o   = '0;
        ram_wdata_o  = '0;
        case (r_state)
            IDLE: begin
                if (w_acc_d && !w_d_err) begin
                    ram_en_o   = 1'b1;
                    ram_addr_o = mem_d_addr_i[RAM_AW+1:2];
                    if (w_d_is_wr) begin
                        // Writes complete in the grant cycle; stay in IDLE.
                        ram_we_o    = mem_d_wr_i;
                        ram_wdata_o = mem_d_data_wr_i;
                    end else begin
                        w_state_next = D_CAP;
                    end
                end else if (w_acc_i && !w_i_err) begin
                    ram_en_o     = 1'b1;
                    ram_addr_o   = mem_i_pc_i[RAM_AW+1:2];
                    w_state_next = I_HI;
                end
            end
            I_HI: begin
                // Low word arrives now; issue the read of the high word.
                ram_en_o     = 1'b1;
                ram_addr_o   = r_fetch_addr + RAM_AW'(1);
                w_state_next = I_CAP;
            end
            I_CAP: w_state_next = IDLE;
            D_CAP: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= IDLE;
            r_fetch_addr <= '0;
            r_inst_lo    <= '0;
            r_d_tag_pend <= '0;
            r_i_valid    <= 1'b0;
            r_i_error    <= 1'b0;
            r_inst       <= '0;
            r_d_ack      <= 1'b0;
            r_d_error    <= 1'b0;
            r_d_rdata    <= '0;
            r_d_tag      <= '0;
        end else begin
            r_state   <= w_state_next;
            // Response strobes are single-cycle pulses; payloads hold.
            r_i_valid <= 1'b0;
            r_d_ack   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc_d) begin
                        if (w_d_err || w_d_is_wr) begin
                            r_d_ack   <= 1'b1;
                            r_d_error <= w_d_err;
                            r_d_rdata <= '0;
                            r_d_tag   <= mem_d_req_tag_i;
                        end else begin
                            r_d_tag_pend <= mem_d_req_tag_i;
                        end
                    end else if (w_acc_i) begin
                        if (w_i_err) begin
                            r_i_valid <= 1'b1;
                            r_i_error <= 1'b1;
                            r_inst    <= '0;
                        end else begin
                            r_fetch_addr <= mem_i_pc_i[RAM_AW+1:2];
                        end
                    end
                end
                I_HI: begin
                    r_inst_lo <= ram_rdata_i;
                end
                I_CAP: begin
                    r_i_valid <= 1'b1;
                    r_i_error <= 1'b0;
                    r_inst    <= {ram_rdata_i, r_inst_lo};
                end
                D_CAP: begin
                    r_d_ack   <= 1'b1;
                    r_d_error <= 1'b0;
                    r_d_rdata <= ram_rdata_i;
                    r_d_tag   <= r_d_tag_pend;
                end
                default: ;
            endcase
        end
    end

    assign mem_i_valid_o    = r_i_valid;
    assign mem_i_error_o    = r_i_error;
    assign mem_i_inst_o     = r_inst;
    assign mem_d_ack_o      = r_d_ack;
    assign mem_d_error_o    = r_d_error;
    assign mem_d_data_rd_o  = r_d_rdata;
    assign mem_d_resp_tag_o = r_d_tag;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural synchronous RAM, directed
// stimulus tasks that push expected responses when a request is accepted,
// and a monitor that pops and compares whenever a response pulse appears.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int RAM_AW = 15;
    localparam int TAG_W  = 11;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              mem_i_rd = 1'b0;
    logic [31:0]       mem_i_pc = '0;
    logic              mem_i_accept_o;
    logic              mem_i_valid_o;
    logic              mem_i_error_o;
    logic [63:0]       mem_i_inst_o;
    logic [31:0]       mem_d_addr = '0;
    logic [31:0]       mem_d_data_wr = '0;
    logic              mem_d_rd = 1'b0;
    logic [3:0]        mem_d_wr = '0;
    logic [TAG_W-1:0]  mem_d_req_tag = '0;
    logic              mem_d_accept_o;
    logic              mem_d_ack_o;
    logic              mem_d_error_o;
    logic [31:0]       mem_d_data_rd_o;
    logic [TAG_W-1:0]  mem_d_resp_tag_o;
    logic              ram_en_o;
    logic [3:0]        ram_we_o;
    logic [RAM_AW-1:0] ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [31:0]       ram_rdata = '0;

    mem_port_arbiter #(.RAM_AW(RAM_AW), .TAG_W(TAG_W)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .mem_i_rd_i       (mem_i_rd),
        .mem_i_pc_i       (mem_i_pc),
        .mem_i_accept_o   (mem_i_accept_o),
        .mem_i_valid_o    (mem_i_valid_o),
        .mem_i_error_o    (mem_i_error_o),
        .mem_i_inst_o     (mem_i_inst_o),
        .mem_d_addr_i     (mem_d_addr),
        .mem_d_data_wr_i  (mem_d_data_wr),
        .mem_d_rd_i       (mem_d_rd),
        .mem_d_wr_i       (mem_d_wr),
        .mem_d_req_tag_i  (mem_d_req_tag),
        .mem_d_accept_o   (mem_d_accept_o),
        .mem_d_ack_o      (mem_d_ack_o),
        .mem_d_error_o    (mem_d_error_o),
        .mem_d_data_rd_o  (mem_d_data_rd_o),
        .mem_d_resp_tag_o (mem_d_resp_tag_o),
        .ram_en_o         (ram_en_o),
        .ram_we_o         (ram_we_o),
        .ram_addr_o       (ram_addr_o),
        .ram_wdata_o      (ram_wdata_o),
        .ram_rdata_i      (ram_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [31:0] ram [0:(1<<RAM_AW)-1];
    initial for (int w = 0; w < (1 << RAM_AW); w++) ram[w] = '0;
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o == 4'b0000) begin
                ram_rdata <= ram[ram_addr_o];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we_o[b]) ram[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic             chk_data;
        int               due;
    } d_exp_t;

    typedef struct {
        logic [63:0] inst;
        logic        err;
        int          due;
    } i_exp_t;

    d_exp_t dq[$];
    i_exp_t iq[$];

    // Monitor: compares every response pulse against the oldest expectation.
    always @(negedge clk) begin
        d_exp_t de;
        i_exp_t ie;
        if (mem_d_ack_o) begin
            $display("d resp cyc=%0d tag=%h data=%h err=%b", cyc, mem_d_resp_tag_o, mem_d_data_rd_o, mem_d_error_o);
            if (dq.size() == 0) begin
                check(1'b0, "d_unexpected", $sformatf("got ack at cyc %0d, required none", cyc));
            end else begin
                de = dq.pop_front();
                check((mem_d_resp_tag_o == de.tag) && (mem_d_error_o == de.err) && (cyc == de.due)
                      && (!de.chk_data || mem_d_data_rd_o == de.data), "d_resp",
                      $sformatf("got tag=%h err=%b data=%h cyc=%0d, required tag=%h err=%b data=%h cyc=%0d",
                                mem_d_resp_tag_o, mem_d_error_o, mem_d_data_rd_o, cyc,
                                de.tag, de.err, de.data, de.due));
            end
        end
        if (mem_i_valid_o) begin
            $display("i resp cyc=%0d inst=%h err=%b", cyc, mem_i_inst_o, mem_i_error_o);
            if (iq.size() == 0) begin
                check(1'b0, "i_unexpected", $sformatf("got valid at cyc %0d, required none", cyc));
            end else begin
                ie = iq.pop_front();
                check((mem_i_inst_o == ie.inst) && (mem_i_error_o == ie.err) && (cyc == ie.due), "i_resp",
                      $sformatf("got inst=%h err=%b cyc=%0d, required inst=%h err=%b cyc=%0d",
                                mem_i_inst_o, mem_i_error_o, cyc, ie.inst, ie.err, ie.due));
            end
        end
    end

    task automatic clear_inputs();
        mem_i_rd      = 1'b0;
        mem_i_pc      = '0;
        mem_d_addr    = '0;
        mem_d_data_wr = '0;
        mem_d_rd      = 1'b0;
        mem_d_wr      = '0;
        mem_d_req_tag = '0;
    endtask

    task automatic d_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wr,
                         input logic rd, input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                         input logic exp_err, input int lat, input logic exp_en, output int waited);
        @(negedge clk);
        mem_d_addr = addr; mem_d_data_wr = wd; mem_d_wr = wr; mem_d_rd = rd; mem_d_req_tag = tag;
        #1;
        waited = 0;
        while (!mem_d_accept_o && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        check(mem_d_accept_o, "d_accept", $sformatf("addr=%h got accept=%b, required 1", addr, mem_d_accept_o));
        if (mem_d_accept_o) begin
            check(ram_en_o == exp_en, "d_ram_en", $sformatf("addr=%h got ram_en=%b, required %b", addr, ram_en_o, exp_en));
            dq.push_back('{exp_data, tag, exp_err, (wr == 4'b0000 || exp_err), cyc + lat});
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic f_txn(input logic [31:0] pc, input logic [63:0] exp_inst, input logic exp_err,
                         input int lat, input logic exp_en);
        int waited;
        @(negedge clk);
        mem_i_rd = 1'b1; mem_i_pc = pc;
        #1;
        waited = 0;
        while (!mem_i_accept_o && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        check(mem_i_accept_o, "i_accept", $sformatf("pc=%h got accept=%b, required 1", pc, mem_i_accept_o));
        if (mem_i_accept_o) begin
            check(ram_en_o == exp_en, "i_ram_en", $sformatf("pc=%h got ram_en=%b, required %b", pc, ram_en_o, exp_en));
            iq.push_back('{exp_inst, exp_err, cyc + lat});
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic check_all_zero(input string name);
        check(!mem_i_valid_o && !mem_i_error_o && (mem_i_inst_o == 64'd0) && !mem_d_ack_o && !mem_d_error_o
              && (mem_d_data_rd_o == 32'd0) && (mem_d_resp_tag_o == '0) && !ram_en_o && (ram_we_o == 4'b0)
              && !mem_i_accept_o && !mem_d_accept_o, name,
              $sformatf("got ival=%b ierr=%b inst=%h dack=%b derr=%b drd=%h tag=%h en=%b we=%b acc=%b%b, required all 0",
                        mem_i_valid_o, mem_i_error_o, mem_i_inst_o, mem_d_ack_o, mem_d_error_o, mem_d_data_rd_o,
                        mem_d_resp_tag_o, ram_en_o, ram_we_o, mem_i_accept_o, mem_d_accept_o));
    endtask

    localparam logic [63:0] INST_40 = 64'h00100093_00000013;

    initial begin
        int  waited;
        bit  pd[8];
        bit  pi[8];
        pd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        pi = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state.
        clear_inputs();
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rstn = 1'b1;

        // Write then read.
        d_txn(32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 11'h012, 32'h0, 1'b0, 1, 1'b1, waited);
        d_txn(32'h100, 32'h0, 4'h0, 1'b1, 11'h013, 32'hDEADBEEF, 1'b0, 2, 1'b1, waited);

        // Fetch of two words preloaded through the data port.
        d_txn(32'h40, 32'h00000013, 4'hF, 1'b0, 11'h001, 32'h0, 1'b0, 1, 1'b1, waited);
        d_txn(32'h44, 32'h00100093, 4'hF, 1'b0, 11'h002, 32'h0, 1'b0, 1, 1'b1, waited);
        f_txn(32'h40, INST_40, 1'b0, 3, 1'b1);
        // Accept stays low in I_HI and I_CAP, then the next fetch is taken.
        @(negedge clk);
        mem_i_rd = 1'b1; mem_i_pc = 32'h40;
        #1 check(!mem_i_accept_o, "accept_low_i_hi", $sformatf("got %b, required 0", mem_i_accept_o));
        @(negedge clk);
        #1 check(!mem_i_accept_o, "accept_low_i_cap", $sformatf("got %b, required 0", mem_i_accept_o));
        @(negedge clk);
        #1 check(mem_i_accept_o, "accept_back_idle", $sformatf("got %b, required 1", mem_i_accept_o));
        if (mem_i_accept_o) iq.push_back('{INST_40, 1'b0, cyc + 3});
        @(posedge clk); #1;
        clear_inputs();

        // Error requests: no RAM access, response at T+1 with zero data.
        f_txn(32'h44, 64'h0, 1'b1, 1, 1'b0);
        f_txn(32'h20000, 64'h0, 1'b1, 1, 1'b0);
        d_txn(32'h20000, 32'h0, 4'h0, 1'b1, 11'h7FF, 32'h0, 1'b1, 1, 1'b0, waited);
        d_txn(32'h20004, 32'h12345678, 4'hF, 1'b0, 11'h055, 32'h0, 1'b1, 1, 1'b0, waited);

        // Byte enables, and write precedence over a simultaneous read.
        d_txn(32'h0, 32'hAABBCCDD, 4'hF, 1'b0, 11'h030, 32'h0, 1'b0, 1, 1'b1, waited);
        d_txn(32'h0, 32'h11223344, 4'b0010, 1'b0, 11'h031, 32'h0, 1'b0, 1, 1'b1, waited);
        d_txn(32'h0, 32'h0, 4'h0, 1'b1, 11'h032, 32'hAABB33DD, 1'b0, 2, 1'b1, waited);
        d_txn(32'h8, 32'h55667788, 4'hF, 1'b1, 11'h033, 32'h0, 1'b0, 1, 1'b1, waited);
        d_txn(32'h8, 32'h0, 4'h0, 1'b1, 11'h034, 32'h55667788, 1'b0, 2, 1'b1, waited);

        // Conflict right after reset: data first, then alternating grants.
        repeat (6) @(negedge clk);
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        mem_i_rd = 1'b1; mem_i_pc = 32'h40;
        mem_d_rd = 1'b1; mem_d_addr = 32'h100; mem_d_req_tag = 11'h021;
        for (int k = 0; k < 8; k++) begin
            #1;
            check((mem_d_accept_o == pd[k]) && (mem_i_accept_o == pi[k]), "conflict_grant",
                  $sformatf("k=%0d got d=%b i=%b, required d=%b i=%b", k, mem_d_accept_o, mem_i_accept_o, pd[k], pi[k]));
            if (mem_d_accept_o) dq.push_back('{32'hDEADBEEF, 11'h021, 1'b0, 1'b1, cyc + 2});
            if (mem_i_accept_o) iq.push_back('{INST_40, 1'b0, cyc + 3});
            if (k < 7) @(negedge clk);
        end
        @(posedge clk); #1;
        clear_inputs();
        repeat (6) @(negedge clk);

        // Reset in the middle of a fetch: outputs clear at once, no response.
        @(negedge clk);
        mem_i_rd = 1'b1; mem_i_pc = 32'h40;
        #1 check(mem_i_accept_o, "mid_fetch_accept", $sformatf("got %b, required 1", mem_i_accept_o));
        @(posedge clk); #1;
        clear_inputs();
        #2 rstn = 1'b0;
        #1 check_all_zero("reset_mid_fetch");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        d_txn(32'h100, 32'h0, 4'h0, 1'b1, 11'h044, 32'hDEADBEEF, 1'b0, 2, 1'b1, waited);
        check(waited == 0, "first_after_reset", $sformatf("got wait=%0d cycles, required 0", waited));

        repeat (10) @(negedge clk);
        check((dq.size() == 0) && (iq.size() == 0), "drain",
              $sformatf("got pending d=%0d i=%0d, required 0 0", dq.size(), iq.size()));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
